ctrl_sel_pipe: RTL and testbench
================================

# ctrl_sel_pipe

Parametrised successor to the control-word select mux in the CPU pipeline. Selects one of NSRC control words, registers it through DEPTH pipeline stages, and supports stall (hold), flush (bubble insertion) and out-of-range select detection. Sits between the decoder/hazard unit and the EX/MEM/WB control latches. It replaces the combinational "zero the control word on hazard" path with a registered, cycle-exact bubble path.

## Interface
Parameters:
- WIDTH, 10, control word width in bits (≥1)
- NSRC, 2, number of candidate control words (≥2)
- DEPTH, 1, number of register stages (≥1)
- BUBBLE, {WIDTH{1'b0}}, control word injected on flush or bad select
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- src  in  NSRC*WIDTH  packed candidates; source k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W = max(1, clog2(NSRC))  source index
- valid_in  in  1  candidate selection valid this cycle
- stall  in  1  hold all stages
- flush  in  1  replace all stages with BUBBLE
- ctrl_out  out  WIDTH  last-stage control word
- valid_out  out  1  last-stage valid
- sel_err  out  1  one-cycle pulse: accepted select was out of range
- bubble_cnt  out  CNT_W  saturating count of bubbles injected

## Operation
- Stage 0 load when not stalled and not flushed:
  - valid_in=1 and sel<NSRC: word = src[sel], valid=1.
  - valid_in=1 and sel≥NSRC: word = BUBBLE, valid=0, sel_err=1 next cycle.
  - valid_in=0: word = BUBBLE, valid=0.
- Stages 1..DEPTH-1 shift from the previous stage on every non-stalled, non-flushed cycle.
- stall=1, flush=0: every stage holds; inputs are ignored; upstream must hold src/sel/valid_in.
- flush=1: all stages load BUBBLE with valid=0 on the next edge. flush overrides stall and valid_in; the current input is discarded.
- bubble_cnt:
  - +1 on each edge where flush=1.
  - +1 on each edge where a bad select is accepted.
  - Saturates at 2^CNT_W-1; never wraps.
  - Maximum +1 per cycle, even if flush and a bad select coincide (flush wins, no sel_err).
- sel_err is asserted only for the accepted cycle. Not asserted while stalled or flushed.
- Reset values: all stages = BUBBLE, valid=0; ctrl_out=BUBBLE, valid_out=0, sel_err=0, bubble_cnt=0. rst overrides stall and flush. Reset mid-stream drops all in-flight words.

## Timing
- Latency: input sampled at edge N appears on ctrl_out/valid_out after edge N+DEPTH-1 (DEPTH registers). No combinational path from inputs to outputs.
- Stall stretches latency by exactly the number of stalled cycles.
- Flush asserted for cycle N: ctrl_out=BUBBLE, valid_out=0 from edge N for every stage. The first new word can enter on cycle N+1.
- sel_err is registered. It is high for exactly the cycle after the bad select was accepted.
- bubble_cnt updates on the same edge as the bubble is injected.

## Structure
- Shared package `ctrl_pipe_pkg`:
  - SEL_W function: max(1, clog2(n)).
  - Default BUBBLE constant.
  - CNT_W default.
- Sub-module `ctrl_pipe_stage`:
  - One register of WIDTH+1 bits (word + valid).
  - Ports: en, flush, d, q.
  - Instantiated DEPTH times via generate.
- Top level holds the select decode, range check, sel_err register and saturating counter.

## Test plan
- Reset: hold rst 2 cycles with stall=1, flush=1 → ctrl_out=0, valid_out=0, sel_err=0, bubble_cnt=0.
- Select and latency, WIDTH=10, NSRC=4, DEPTH=3:
  - Stimulus: src = {0x3FF, 0x155, 0x0AA, 0x001}, sel=2, valid_in=1 at cycle 0.
  - Required: ctrl_out=0x155, valid_out=1 after the 3rd edge.
- Stall:
  - Stimulus: stream sel=0,1,2,3, then stall for 2 cycles mid-stream.
  - Required: outputs 0x001, 0x0AA, 0x155, 0x3FF in order, each delayed by exactly 2 cycles after the stall; no duplicates or drops.
- Flush over stall:
  - Stimulus: 3 valid words in flight; flush=1 and stall=1 together.
  - Required: next cycle all stages BUBBLE, valid_out=0 for 3 cycles, bubble_cnt=1.
- Bad select:
  - Stimulus: NSRC=3, sel=3, valid_in=1.
  - Required: sel_err=1 for exactly one cycle, bubble_cnt+1, and valid_out=0 at that slot.
  - Stimulus: sel=3 with flush=1.
  - Required: sel_err=0 and bubble_cnt+1 only.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive flushes.
  - Required: bubble_cnt stops at 15.
  - Stimulus: rst.
  - Required: bubble_cnt returns to 0.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and helpers for the control-word select pipeline.
package ctrl_pipe_pkg;

   // Default bubble counter width.
   localparam int DEF_CNT_W = 16;

   // Default bubble word is all zeros (a no-op control word).
   localparam logic DEF_BUBBLE_BIT = 1'b0;

   // Select index width: at least one bit, even for tiny source counts.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline register holding a control word plus its valid bit.
module ctrl_pipe_stage #(
   parameter int           W       = 11,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Reset and flush both force the bubble; otherwise load when enabled.
   always_ff @(posedge clk) begin
      if (rst || flush) q <= RST_VAL;
      else if (en)      q <= d;
   end

endmodule

// File: rtl/ctrl_sel_pipe.sv
// Control-word select mux feeding a DEPTH-stage registered pipeline with
// stall, flush-to-bubble, bad-select detection and a bubble counter.
module ctrl_sel_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int               WIDTH  = 10,
   parameter int               NSRC   = 2,
   parameter int               DEPTH  = 1,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{DEF_BUBBLE_BIT}},
   parameter int               CNT_W  = DEF_CNT_W,
   localparam int              SEL_W  = sel_w(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSRC*WIDTH-1:0] src,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  valid_in,
   input  logic                  stall,
   input  logic                  flush,
   output logic [WIDTH-1:0]      ctrl_out,
   output logic                  valid_out,
   output logic                  sel_err,
   output logic [CNT_W-1:0]      bubble_cnt
);

   logic [WIDTH-1:0] pick;
   logic             in_range;
   logic             accept;
   logic             bad;
   logic [WIDTH:0]   stq [DEPTH+1];

   // Decode the select; anything past NSRC-1 is out of range and yields BUBBLE.
   always_comb begin
      pick     = BUBBLE;
      in_range = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (sel == SEL_W'(k)) begin
            pick     = src[k*WIDTH +: WIDTH];
            in_range = 1'b1;
         end
      end
   end

   // A select only counts as accepted on a cycle the pipe actually loads.
   assign accept = valid_in & ~stall & ~flush;
   assign bad    = accept & ~in_range;

   // Stage-0 input: word in upper bits, valid in bit 0.
   assign stq[0] = {(valid_in ? pick : BUBBLE), valid_in & in_range};

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_stage
         ctrl_pipe_stage #(
            .W       (WIDTH+1),
            .RST_VAL ({BUBBLE, 1'b0})
         ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (~stall),
            .flush (flush),
            .d     (stq[g]),
            .q     (stq[g+1])
         );
      end
   endgenerate

   assign ctrl_out  = stq[DEPTH][WIDTH:1];
   assign valid_out = stq[DEPTH][0];

   // Error pulse and saturating bubble count; flush and bad select share one increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err    <= 1'b0;
         bubble_cnt <= '0;
      end else begin
         sel_err <= bad;
         if ((flush || bad) && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ctrl_sel_pipe.sv
// Self-checking bench: directed vector table, saturation sequence and
// randomized traffic against a queue-based reference model.
module tb_ctrl_sel_pipe;

   localparam int WIDTH = 10;
   localparam int NSRC  = 5;
   localparam int DEPTH = 3;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, stall, flush, valid_in;
   logic [NSRC*WIDTH-1:0] src;
   logic [2:0]       sel;
   logic [WIDTH-1:0] ctrl_out;
   logic             valid_out, sel_err;
   logic [CNT_W-1:0] bubble_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ctrl_sel_pipe #(
      .WIDTH(WIDTH), .NSRC(NSRC), .DEPTH(DEPTH), .BUBBLE(10'h000), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .src(src), .sel(sel), .valid_in(valid_in),
      .stall(stall), .flush(flush), .ctrl_out(ctrl_out), .valid_out(valid_out),
      .sel_err(sel_err), .bubble_cnt(bubble_cnt)
   );

   // ---------------- reference model ----------------
   typedef struct { logic [WIDTH-1:0] w; bit v; } ent_t;
   ent_t mq[$];
   int   mcnt;
   bit   merr;

   task automatic model_clear();
      ent_t e;
      e.w = '0; e.v = 1'b0;
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back(e);
   endtask

   task automatic model_edge();
      ent_t e;
      int   idx;
      bit   bs;
      if (rst) begin
         model_clear(); mcnt = 0; merr = 1'b0;
      end else if (flush) begin
         model_clear(); merr = 1'b0;
         if (mcnt < CMAX) mcnt++;
      end else if (stall) begin
         merr = 1'b0;
      end else begin
         idx = int'(sel);
         bs  = valid_in && (idx >= NSRC);
         e.v = valid_in && !bs;
         e.w = e.v ? src[idx*WIDTH +: WIDTH] : '0;
         mq.push_front(e);
         void'(mq.pop_back());
         merr = bs;
         if (bs && mcnt < CMAX) mcnt++;
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, step the model on the edge, settle past it.
   task automatic cyc(input bit r, input bit s, input bit f, input bit v, input logic [2:0] sl);
      rst = r; stall = s; flush = f; valid_in = v; sel = sl;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit r, s, f, v;
      logic [2:0]       sl;
      logic [WIDTH-1:0] ec;
      bit               ev, ee;
      logic [CNT_W-1:0] cn;
   } vec_t;

   function automatic vec_t mk(bit r, bit s, bit f, bit v, logic [2:0] sl,
                               logic [WIDTH-1:0] ec, bit ev, bit ee, logic [CNT_W-1:0] cn);
      vec_t t;
      t.r = r; t.s = s; t.f = f; t.v = v; t.sl = sl;
      t.ec = ec; t.ev = ev; t.ee = ee; t.cn = cn;
      return t;
   endfunction

   vec_t tbl[35];

   initial begin
      logic [63:0] rnd;

      rst = 1'b1; stall = 1'b1; flush = 1'b1; valid_in = 1'b0; sel = '0;
      src = {10'h2C3, 10'h3FF, 10'h155, 10'h0AA, 10'h001};
      model_clear(); mcnt = 0; merr = 1'b0;

      //             r  s  f  v  sel  ctrl    vo ee cnt
      tbl[0]  = mk(1, 1, 1, 0, 3'd0, 10'h000, 0, 0, 0);  // reset with stall+flush
      tbl[1]  = mk(1, 1, 1, 0, 3'd0, 10'h000, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 3'd2, 10'h000, 0, 0, 0);  // select src[2]
      tbl[3]  = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 3'd0, 10'h155, 1, 0, 0);  // after 3rd edge
      tbl[5]  = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 3'd0, 10'h000, 0, 0, 0);  // stream 0..3 with stall
      tbl[7]  = mk(0, 0, 0, 1, 3'd1, 10'h000, 0, 0, 0);
      tbl[8]  = mk(0, 1, 0, 1, 3'd2, 10'h000, 0, 0, 0);
      tbl[9]  = mk(0, 1, 0, 1, 3'd2, 10'h000, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 1, 3'd2, 10'h001, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 1, 3'd3, 10'h0AA, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 3'd0, 10'h155, 1, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 3'd0, 10'h3FF, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 1, 3'd0, 10'h000, 0, 0, 0);  // fill, then flush over stall
      tbl[16] = mk(0, 0, 0, 1, 3'd1, 10'h000, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 1, 3'd2, 10'h001, 1, 0, 0);
      tbl[18] = mk(0, 1, 1, 1, 3'd3, 10'h000, 0, 0, 1);
      tbl[19] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1);
      tbl[20] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 1);
      tbl[21] = mk(0, 0, 0, 1, 3'd5, 10'h000, 0, 1, 2);  // bad select
      tbl[22] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 2);
      tbl[23] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 2);
      tbl[24] = mk(0, 0, 1, 1, 3'd7, 10'h000, 0, 0, 3);  // bad select under flush
      tbl[25] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 3);
      tbl[26] = mk(0, 1, 0, 1, 3'd6, 10'h000, 0, 0, 3);  // bad select while stalled
      tbl[27] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 3);
      tbl[28] = mk(0, 0, 0, 1, 3'd4, 10'h000, 0, 0, 3);  // top in-range index
      tbl[29] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 3);
      tbl[30] = mk(0, 0, 0, 0, 3'd0, 10'h2C3, 1, 0, 3);
      tbl[31] = mk(0, 0, 0, 1, 3'd0, 10'h000, 0, 0, 3);
      tbl[32] = mk(1, 0, 0, 1, 3'd1, 10'h000, 0, 0, 0);  // reset mid-stream
      tbl[33] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0);
      tbl[34] = mk(0, 0, 0, 0, 3'd0, 10'h000, 0, 0, 0);

      for (int i = 0; i < 35; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].sl);
         chk($sformatf("tbl%0d ctrl_out", i),  16'(ctrl_out),   16'(tbl[i].ec));
         chk($sformatf("tbl%0d valid_out", i), 16'(valid_out),  16'(tbl[i].ev));
         chk($sformatf("tbl%0d sel_err", i),   16'(sel_err),    16'(tbl[i].ee));
         chk($sformatf("tbl%0d bubble_cnt", i),16'(bubble_cnt), 16'(tbl[i].cn));
      end

      // Saturation: 20 back-to-back flushes, then reset clears the count.
      cyc(1, 0, 0, 0, 3'd0);
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 1, 1, 3'd0);
         chk($sformatf("sat%0d bubble_cnt", i), 16'(bubble_cnt), 16'((i > CMAX) ? CMAX : i));
      end
      cyc(1, 0, 0, 0, 3'd0);
      chk("sat rst bubble_cnt", 16'(bubble_cnt), 16'(0));

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         rnd = {$urandom(), $urandom()};
         src = rnd[NSRC*WIDTH-1:0];
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 75,
             3'($urandom_range(0, 7)));
         chk("rnd ctrl_out",   16'(ctrl_out),   16'(mq[DEPTH-1].w));
         chk("rnd valid_out",  16'(valid_out),  16'(mq[DEPTH-1].v));
         chk("rnd sel_err",    16'(sel_err),    16'(merr));
         chk("rnd bubble_cnt", 16'(bubble_cnt), 16'(mcnt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
